pipelined_addsub: RTL

Parametrised, pipelined N-bit adder/subtractor with a valid/ready handshake, carry-in, and carry/overflow flags. It is the sequential successor to the team's combinational N-bit adder. The carry chain is split across S register stages so wide operands close timing, and a stall path gives full downstream backpressure. It sits in the arithmetic datapath between operand producers and result consumers that each use valid/ready.

---
 rtl/pipelined_addsub.sv | 107 ++++++++++
 1 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined N-bit adder/subtractor. The carry chain is cut into S slices with one register
// stage per slice, and a global valid/ready stall gives full downstream backpressure.
module pipelined_addsub #(
  parameter int N = 8,
  parameter int S = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic         C_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Z,
  output logic         C_out,
  output logic         V
);

  localparam int W = N / S;

  logic [S-1:0] valid_q;
  logic [S-1:0] valid_d;
  logic [S-1:0] carry_q;
  logic [S-1:0] carry_d;
  logic [N-1:0] opA_q [S];
  logic [N-1:0] opA_d [S];
  logic [N-1:0] opB_q [S];
  logic [N-1:0] opB_d [S];
  logic [N-1:0] res_q [S];
  logic [N-1:0] res_d [S];
  logic         ovf_q;
  logic         ovf_d;

  logic [S-1:0] carryIn;
  logic [N-1:0] resIn [S];
  logic [W:0]   sliceSum;
  logic         msbCarryIn;
  logic         adv;

  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  // Stage inputs: stage 0 takes the operands directly, later stages take the skew/de-skew registers
  // of the stage before. Subtract feeds ~Y with a forced carry-in so it is X + ~Y + 1.
  always_comb begin
    valid_d    = '0;
    carryIn    = '0;
    valid_d[0] = in_valid;
    opA_d[0]   = X;
    opB_d[0]   = sub ? ~Y : Y;
    carryIn[0] = sub | C_in;
    resIn[0]   = '0;
    for (int k = 1; k < S; k++) begin
      valid_d[k] = valid_q[k-1];
      opA_d[k]   = opA_q[k-1];
      opB_d[k]   = opB_q[k-1];
      carryIn[k] = carry_q[k-1];
      resIn[k]   = res_q[k-1];
    end
  end

  always_comb begin
    sliceSum   = '0;
    carry_d    = '0;
    for (int k = 0; k < S; k++) begin
      sliceSum = {1'b0, opA_d[k][k*W +: W]} + {1'b0, opB_d[k][k*W +: W]}
               + {{W{1'b0}}, carryIn[k]};
      res_d[k] = resIn[k];
      res_d[k][k*W +: W] = sliceSum[W-1:0];
      carry_d[k] = sliceSum[W];
    end
    // The carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    msbCarryIn = opA_d[S-1][N-1] ^ opB_d[S-1][N-1] ^ res_d[S-1][N-1];
    ovf_d      = msbCarryIn ^ carry_d[S-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < S; k++) begin
        opA_q[k] <= '0;
        opB_q[k] <= '0;
        res_q[k] <= '0;
      end
    end else if (adv) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < S; k++) begin
        opA_q[k] <= opA_d[k];
        opB_q[k] <= opB_d[k];
        res_q[k] <= res_d[k];
      end
    end
  end

  assign out_valid = valid_q[S-1];
  assign Z         = res_q[S-1];
  assign C_out     = carry_q[S-1];
  assign V         = ovf_q;

endmodule
